// File: rtl/input_replay_sequencer_if.sv
// Handshake/bus bundle between the game top and the input replay sequencer.
// The master side drives requests, live keys and script ROM data.
interface input_replay_sequencer_if #(
    parameter int NUM_CH = 2,
    parameter int KEY_W  = 4,
    parameter int DUR_W  = 8,
    parameter int DEPTH  = 64
);
    localparam int AW = $clog2(DEPTH);
    localparam int KW = NUM_CH * KEY_W;
    localparam int RW = 1 + DUR_W + KW;

    logic          start;
    logic          stop;
    logic          loop_en;
    logic          frame_tick;
    logic [KW-1:0] live_keys;
    logic [AW-1:0] rom_addr;
    logic [RW-1:0] rom_data;
    logic [KW-1:0] keys_out;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [AW-1:0] cur_index;

    modport master (
        output start, stop, loop_en, frame_tick, live_keys, rom_data,
        input  rom_addr, keys_out, busy, done, aborted, cur_index
    );

    modport slave (
        input  start, stop, loop_en, frame_tick, live_keys, rom_data,
        output rom_addr, keys_out, busy, done, aborted, cur_index
    );
endinterface

// File: rtl/input_replay_sequencer.sv
// Scripted key playback engine: walks timed key-state entries from a script
// ROM and drives the per-player action bus, passing live keys through when idle.
module input_replay_sequencer #(
    parameter int NUM_CH        = 2,
    parameter int KEY_W         = 4,
    parameter int DEPTH         = 64,
    parameter int DUR_W         = 8,
    parameter bit ABORT_ON_LIVE = 1'b1
) (
    input logic                    clk_i,
    input logic                    rst_i,
    input_replay_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int KW = NUM_CH * KEY_W;
    localparam logic [AW-1:0] IDX_MAX = AW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, HOLD} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [AW-1:0]    cur_q, cur_d;
    logic [DUR_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic [KW-1:0]    keys_q, keys_d;
    logic             busy_q;
    logic             done_q, done_d;
    logic             abort_q, abort_d;

    logic             rom_last;
    logic [DUR_W-1:0] rom_dur;
    logic [KW-1:0]    rom_keys;
    logic             live_abort;

    assign {rom_last, rom_dur, rom_keys} = bus.rom_data;
    assign live_abort = ABORT_ON_LIVE && (bus.live_keys != '0);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        keys_d  = keys_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        if (state_q == IDLE) begin
            keys_d = bus.live_keys;
            if (bus.start && !bus.stop) begin
                state_d = FETCH;
                idx_d   = '0;
                keys_d  = '0;
            end
        end else if (bus.stop) begin
            state_d = IDLE;
            keys_d  = '0;
        end else if (live_abort) begin
            state_d = IDLE;
            keys_d  = bus.live_keys;
            abort_d = 1'b1;
        end else begin
            // keys_q is left alone in FETCH so entries change without a gap
            unique case (state_q)
                FETCH: state_d = LOAD;
                LOAD: begin
                    keys_d  = rom_keys;
                    cnt_d   = (rom_dur == '0) ? DUR_W'(1) : rom_dur;
                    last_d  = rom_last | (idx_q == IDX_MAX);
                    cur_d   = idx_q;
                    state_d = HOLD;
                end
                HOLD: begin
                    if (bus.frame_tick) begin
                        if (cnt_q > DUR_W'(1)) begin
                            cnt_d = cnt_q - DUR_W'(1);
                        end else if (!last_q) begin
                            idx_d   = idx_q + AW'(1);
                            state_d = FETCH;
                        end else if (bus.loop_en) begin
                            idx_d   = '0;
                            state_d = FETCH;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cur_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            keys_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            keys_q  <= keys_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign bus.rom_addr  = idx_q;
    assign bus.keys_out  = keys_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.aborted   = abort_q;
    assign bus.cur_index = cur_q;
endmodule

// File: tb/tb_input_replay_sequencer.sv
// Bench for input_replay_sequencer: three instances (default, abort disabled,
// 4-entry script) against a frame-level playback model, plus literal checks.
module tb_input_replay_sequencer;
    localparam int RW = 17;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop_en = 1'b0;
    logic       tick = 1'b0;
    logic [7:0] live = 8'h00;
    logic [RW-1:0] rom [64];

    int checks = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    input_replay_sequencer_if #(.DEPTH(64)) if0 ();
    input_replay_sequencer_if #(.DEPTH(64)) if1 ();
    input_replay_sequencer_if #(.DEPTH(4))  if2 ();

    input_replay_sequencer #(.DEPTH(64), .ABORT_ON_LIVE(1'b1)) u0 (
        .clk_i(clk), .rst_i(rst), .bus(if0));
    input_replay_sequencer #(.DEPTH(64), .ABORT_ON_LIVE(1'b0)) u1 (
        .clk_i(clk), .rst_i(rst), .bus(if1));
    input_replay_sequencer #(.DEPTH(4), .ABORT_ON_LIVE(1'b1)) u2 (
        .clk_i(clk), .rst_i(rst), .bus(if2));

    assign if0.start = start;   assign if1.start = start;   assign if2.start = start;
    assign if0.stop = stop;     assign if1.stop = stop;     assign if2.stop = stop;
    assign if0.loop_en = loop_en; assign if1.loop_en = loop_en; assign if2.loop_en = loop_en;
    assign if0.frame_tick = tick; assign if1.frame_tick = tick; assign if2.frame_tick = tick;
    assign if0.live_keys = live; assign if1.live_keys = live; assign if2.live_keys = live;

    // synchronous script ROM, one read port per instance
    always @(posedge clk) begin
        if0.rom_data <= rom[if0.rom_addr];
        if1.rom_data <= rom[if1.rom_addr];
        if2.rom_data <= rom[if2.rom_addr];
    end

    logic [7:0] ko [3];
    logic       bz [3];
    logic       dn [3];
    logic       ab [3];
    int         ci [3];
    int         ra [3];
    assign ko[0] = if0.keys_out; assign ko[1] = if1.keys_out; assign ko[2] = if2.keys_out;
    assign bz[0] = if0.busy;     assign bz[1] = if1.busy;     assign bz[2] = if2.busy;
    assign dn[0] = if0.done;     assign dn[1] = if1.done;     assign dn[2] = if2.done;
    assign ab[0] = if0.aborted;  assign ab[1] = if1.aborted;  assign ab[2] = if2.aborted;
    assign ci[0] = int'(if0.cur_index);
    assign ci[1] = int'(if1.cur_index);
    assign ci[2] = int'(if2.cur_index);
    assign ra[0] = int'(if0.rom_addr);
    assign ra[1] = int'(if1.rom_addr);
    assign ra[2] = int'(if2.rom_addr);

    // playback model: entry index, frames left, cycles until the entry appears
    typedef struct packed {
        logic       busy;
        logic [7:0] keys;
        int         cur;
        int         idx;
        int         rem;
        logic       last;
        int         pend;
        logic       done;
        logic       ab;
    } mdl_t;

    mdl_t m [3];
    int depth_of [3] = '{64, 64, 4};
    bit abt_of [3] = '{1'b1, 1'b0, 1'b1};

    function automatic mdl_t step(mdl_t s, int depth, bit abt);
        mdl_t n;
        logic [RW-1:0] e;
        n = s;
        n.done = 1'b0;
        n.ab = 1'b0;
        if (rst) begin
            n = '0;
        end else if (!s.busy) begin
            if (start && !stop) begin
                n.busy = 1'b1;
                n.keys = 8'h00;
                n.idx = 0;
                n.pend = 2;
            end else begin
                n.keys = live;
            end
        end else if (stop) begin
            n.busy = 1'b0;
            n.keys = 8'h00;
        end else if (abt && live != 8'h00) begin
            n.busy = 1'b0;
            n.keys = live;
            n.ab = 1'b1;
        end else if (s.pend > 0) begin
            n.pend = s.pend - 1;
            if (n.pend == 0) begin
                e = rom[s.idx];
                n.keys = e[7:0];
                n.rem = (e[15:8] == 8'd0) ? 1 : int'(e[15:8]);
                n.last = e[16] || (s.idx == depth - 1);
                n.cur = s.idx;
            end
        end else if (tick) begin
            if (s.rem > 1) begin
                n.rem = s.rem - 1;
            end else if (!s.last) begin
                n.idx = s.idx + 1;
                n.pend = 2;
            end else if (loop_en) begin
                n.idx = 0;
                n.pend = 2;
            end else begin
                n.busy = 1'b0;
                n.done = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) m[i] <= step(m[i], depth_of[i], abt_of[i]);
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("keys%0d", i), 32'(ko[i]), 32'(m[i].keys));
                chk($sformatf("busy%0d", i), 32'(bz[i]), 32'(m[i].busy));
                chk($sformatf("done%0d", i), 32'(dn[i]), 32'(m[i].done));
                chk($sformatf("abort%0d", i), 32'(ab[i]), 32'(m[i].ab));
                chk($sformatf("cur%0d", i), ci[i], m[i].cur);
                chk($sformatf("addr%0d", i), ra[i], m[i].idx);
            end
            if (if0.done) done_cnt++;
        end
    end

    task automatic drive(bit s, bit p, bit t, logic [7:0] lv);
        start = s;
        stop = p;
        tick = t;
        live = lv;
        @(posedge clk);
        #2;
        start = 1'b0;
        stop = 1'b0;
        tick = 1'b0;
        live = 8'h00;
    endtask

    task automatic idle(int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic quiesce();
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        idle(2);
    endtask

    task automatic rom_t2();
        rom[0] = {1'b0, 8'd2, 8'h11};
        rom[1] = {1'b0, 8'd1, 8'h24};
        rom[2] = {1'b1, 8'd3, 8'h00};
    endtask

    logic [7:0] seq [6];
    int base;

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = '0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_keys", 32'(if0.keys_out), 32'h0);
        chk("rst_busy", 32'(if0.busy), 32'h0);

        // reset while entry 3 is being held
        rom[0] = {1'b0, 8'd1, 8'h01};
        rom[1] = {1'b0, 8'd1, 8'h02};
        rom[2] = {1'b0, 8'd1, 8'h04};
        rom[3] = {1'b1, 8'd200, 8'h21};
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        repeat (14) drive(1'b0, 1'b0, 1'b1, 8'h00);
        chk("t1_keys_hold", 32'(if0.keys_out), 32'h21);
        chk("t1_cur_hold", 32'(if0.cur_index), 32'd3);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("t1_keys", 32'(if0.keys_out), 32'h0);
        chk("t1_busy", 32'(if0.busy), 32'h0);
        chk("t1_cur", 32'(if0.cur_index), 32'h0);
        chk("t1_addr", 32'(if0.rom_addr), 32'h0);
        idle(2);

        // three-entry script, one tick every 10 cycles
        rom_t2();
        loop_en = 1'b0;
        base = done_cnt;
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        for (int f = 0; f < 6; f++) begin
            idle(9);
            seq[f] = if0.keys_out;
            drive(1'b0, 1'b0, 1'b1, 8'h00);
        end
        chk("t2_done", 32'(if0.done), 32'h1);
        chk("t2_busy", 32'(if0.busy), 32'h0);
        chk("t2_f0", 32'(seq[0]), 32'h11);
        chk("t2_f1", 32'(seq[1]), 32'h11);
        chk("t2_f2", 32'(seq[2]), 32'h24);
        chk("t2_f3", 32'(seq[3]), 32'h00);
        chk("t2_f5", 32'(seq[5]), 32'h00);
        idle(20);
        chk("t2_done_cnt", done_cnt - base, 1);

        // same script looping for 20 frames
        loop_en = 1'b1;
        base = done_cnt;
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        for (int f = 0; f < 20; f++) begin
            idle(9);
            if (f == 6) begin
                chk("t3_keys_wrap", 32'(if0.keys_out), 32'h11);
                chk("t3_cur_wrap", 32'(if0.cur_index), 32'd0);
            end
            drive(1'b0, 1'b0, 1'b1, 8'h00);
        end
        chk("t3_no_done", done_cnt - base, 0);
        loop_en = 1'b0;
        quiesce();

        // live input during entry 1
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        for (int f = 0; f < 2; f++) begin
            idle(9);
            drive(1'b0, 1'b0, 1'b1, 8'h00);
        end
        idle(5);
        drive(1'b0, 1'b0, 1'b0, 8'h04);
        chk("t4_abort", 32'(if0.aborted), 32'h1);
        chk("t4_keys", 32'(if0.keys_out), 32'h04);
        chk("t4_busy", 32'(if0.busy), 32'h0);
        chk("t4_noab_busy", 32'(if1.busy), 32'h1);
        chk("t4_noab_keys", 32'(if1.keys_out), 32'h24);
        quiesce();

        // zero duration entry and a 4-entry script with no last flag
        rom[0] = {1'b0, 8'd1, 8'h01};
        rom[1] = {1'b0, 8'd0, 8'h02};
        rom[2] = {1'b0, 8'd1, 8'h04};
        rom[3] = {1'b0, 8'd1, 8'h08};
        rom[4] = {1'b1, 8'd1, 8'h00};
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        for (int f = 0; f < 4; f++) begin
            idle(4);
            seq[f] = if2.keys_out;
            drive(1'b0, 1'b0, 1'b1, 8'h00);
        end
        chk("t5_f0", 32'(seq[0]), 32'h01);
        chk("t5_f1", 32'(seq[1]), 32'h02);
        chk("t5_f2", 32'(seq[2]), 32'h04);
        chk("t5_f3", 32'(seq[3]), 32'h08);
        chk("t5_done", 32'(if2.done), 32'h1);
        chk("t5_cur", 32'(if2.cur_index), 32'd3);
        quiesce();

        // start with stop, then start while busy
        rom_t2();
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        chk("t6_ss_busy", 32'(if0.busy), 32'h0);
        idle(1);
        chk("t6_ss_busy2", 32'(if0.busy), 32'h0);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        for (int f = 0; f < 2; f++) begin
            idle(9);
            drive(1'b0, 1'b0, 1'b1, 8'h00);
        end
        idle(5);
        chk("t6_cur1", 32'(if0.cur_index), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        chk("t6_cur1_kept", 32'(if0.cur_index), 32'd1);
        idle(4);
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        idle(5);
        chk("t6_cur2", 32'(if0.cur_index), 32'd2);
        quiesce();

        // randomized script and traffic
        for (int i = 0; i < 64; i++)
            rom[i] = {($urandom_range(7) == 0), 8'($urandom_range(3)), 8'($urandom)};
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(199) == 0) loop_en = ~loop_en;
            drive($urandom_range(15) == 0, $urandom_range(99) == 0,
                  $urandom_range(2) == 0,
                  ($urandom_range(39) == 0) ? 8'($urandom) : 8'h00);
        end
        quiesce();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
